// File: rtl/pc_seq_unit.sv
// pc_seq_unit - program-counter sequencer for the RV32I core.
//
// Holds the PC, issues fetch requests over a req/ack handshake, and applies
// the next-PC select (SEQ, BRANCH, JAL, JALR, HOLD) when execute reports done.
//
// Optional feature macro: PC_TRAP_EN
//   defined   : misaligned jump/branch target redirects to TRAP_VECTOR and
//               records the faulting PC in trap_pc.
//   undefined : misaligned target is truncated to the alignment boundary,
//               trap_pc stays 0.
//
// Ports:
//   clk           in   system clock, rising edge
//   clr           in   synchronous active-low reset
//   fetch_ack     in   instruction word for pc_val returned (REQ only)
//   update_en     in   execute done, apply next-PC select (EXEC only)
//   sel[2:0]      in   000 SEQ, 001 BRANCH, 010 JAL, 011 JALR, 100 HOLD
//   branch_taken  in   branch condition result
//   imm           in   signed byte offset
//   rs1_val       in   JALR base register
//   halt          in   stop sequencing (wins over update_en)
//   pc_val        out  current PC
//   fetch_req     out  registered fetch request
//   link_addr     out  pc_val + 4
//   instr_count   out  completed update count (wraps)
//   misalign_err  out  one-cycle pulse on misaligned target
//   halted        out  high in HALTED
//   trap_pc       out  faulting PC (PC_TRAP_EN), else 0

module pc_seq_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int                ALIGN        = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            fetch_ack,
    input  logic            update_en,
    input  logic [2:0]      sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            halt,
    output logic [XLEN-1:0] pc_val,
    output logic            fetch_req,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] instr_count,
    output logic            misalign_err,
    output logic            halted,
    output logic [XLEN-1:0] trap_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALTED
    } state_t;

    // Low address bits that must be zero for a legal target.
    localparam logic [XLEN-1:0] LOW_MASK = (ALIGN == 2) ? XLEN'(1) : XLEN'(3);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic            fetch_req_q, fetch_req_d;
    logic            mis_q, mis_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] target;
    logic            chk_en;
    logic            tgt_mis;

    // Target selection; SEQ/HOLD/unknown selects never flag misalignment.
    always_comb begin
        pc_seq = pc_q + XLEN'(4);
        target = pc_seq;
        chk_en = 1'b0;
        case (sel)
            3'b001: begin
                target = branch_taken ? (pc_q + imm) : pc_seq;
                chk_en = 1'b1;
            end
            3'b010: begin
                target = pc_q + imm;
                chk_en = 1'b1;
            end
            3'b011: begin
                target = (rs1_val + imm) & ~XLEN'(1);
                chk_en = 1'b1;
            end
            3'b100: target = pc_q;
            default: target = pc_seq;
        endcase
        tgt_mis = chk_en && ((target & LOW_MASK) != '0);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        trap_pc_d   = trap_pc_q;
        fetch_req_d = fetch_req_q;
        mis_d       = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            S_IDLE: begin
                state_d     = S_REQ;
                fetch_req_d = 1'b1;
            end
            S_REQ: begin
                if (fetch_ack) begin
                    state_d     = S_EXEC;
                    fetch_req_d = 1'b0;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else if (update_en) begin
                    state_d     = S_REQ;
                    fetch_req_d = 1'b1;
                    cnt_d       = cnt_q + XLEN'(1);
                    mis_d       = tgt_mis;
                    if (tgt_mis) begin
`ifdef PC_TRAP_EN
                        pc_d      = TRAP_VECTOR;
                        trap_pc_d = pc_q;
`else
                        pc_d      = target & ~LOW_MASK;
`endif
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: begin
                // HALTED: sticky until reset.
                fetch_req_d = 1'b0;
                halted_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            cnt_q       <= '0;
            trap_pc_q   <= '0;
            fetch_req_q <= 1'b0;
            mis_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            trap_pc_q   <= trap_pc_d;
            fetch_req_q <= fetch_req_d;
            mis_q       <= mis_d;
            halted_q    <= halted_d;
        end
    end

    assign pc_val       = pc_q;
    assign fetch_req    = fetch_req_q;
    assign link_addr    = pc_q + XLEN'(4);
    assign instr_count  = cnt_q;
    assign misalign_err = mis_q;
    assign halted       = halted_q;
    assign trap_pc      = trap_pc_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit. Three instances share one stimulus stream:
// d4 (XLEN=32, ALIGN=4), d2 (XLEN=32, ALIGN=2) and d8 (XLEN=8) for the
// counter wrap. All follow the same state sequence; only PC values differ.

module tb_pc_seq_unit;

    localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JAL = 3'b010,
                           JALR = 3'b011, HOLD = 3'b100;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        update_en = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic        branch_taken = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_val = '0;
    logic        halt = 1'b0;

    logic [31:0] pc4, link4, cnt4, trap4;
    logic        req4, mis4, hlt4;
    logic [31:0] pc2, link2, cnt2, trap2;
    logic        req2, mis2, hlt2;
    logic [7:0]  pc8, link8, cnt8, trap8;
    logic        req8, mis8, hlt8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_seq_unit #(.XLEN(32), .ALIGN(4)) d4 (
        .clk(clk), .clr(clr), .fetch_ack(fetch_ack), .update_en(update_en),
        .sel(sel), .branch_taken(branch_taken), .imm(imm), .rs1_val(rs1_val),
        .halt(halt), .pc_val(pc4), .fetch_req(req4), .link_addr(link4),
        .instr_count(cnt4), .misalign_err(mis4), .halted(hlt4), .trap_pc(trap4));

    pc_seq_unit #(.XLEN(32), .ALIGN(2)) d2 (
        .clk(clk), .clr(clr), .fetch_ack(fetch_ack), .update_en(update_en),
        .sel(sel), .branch_taken(branch_taken), .imm(imm), .rs1_val(rs1_val),
        .halt(halt), .pc_val(pc2), .fetch_req(req2), .link_addr(link2),
        .instr_count(cnt2), .misalign_err(mis2), .halted(hlt2), .trap_pc(trap2));

    pc_seq_unit #(.XLEN(8), .TRAP_VECTOR(8'h80), .ALIGN(4)) d8 (
        .clk(clk), .clr(clr), .fetch_ack(fetch_ack), .update_en(update_en),
        .sel(sel), .branch_taken(branch_taken), .imm(imm[7:0]),
        .rs1_val(rs1_val[7:0]), .halt(halt), .pc_val(pc8), .fetch_req(req8),
        .link_addr(link8), .instr_count(cnt8), .misalign_err(mis8),
        .halted(hlt8), .trap_pc(trap8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From REQ: ack the fetch, then apply one update on the first EXEC cycle.
    task automatic do_instr(input logic [2:0] s, input logic [31:0] im,
                            input logic [31:0] r, input logic tk);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        sel = s; imm = im; rs1_val = r; branch_taken = tk;
        update_en = 1'b1;
        step();
        update_en = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_pc", pc4, 64'h0);
        chk("rst_req", req4, 64'h0);
        chk("rst_cnt", cnt4, 64'h0);
        chk("rst_halted", hlt4, 64'h0);
        chk("rst_mis", mis4, 64'h0);
        chk("rst_trap", trap4, 64'h0);

        // IDLE -> REQ
        clr = 1'b1;
        step();
        chk("req_after_idle", req4, 64'h1);

        // Ack: fetch_req drops in EXEC
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("exec_req_low", req4, 64'h0);
        sel = SEQ; update_en = 1'b1;
        step();
        update_en = 1'b0;
        chk("seq_pc", pc4, 64'h4);
        chk("seq_cnt", cnt4, 64'h1);
        chk("seq_req", req4, 64'h1);

        do_instr(JAL, 32'h3C, 32'h0, 1'b0);
        chk("jal_pc", pc4, 64'h40);
        chk("link_addr", link4, 64'h44);

        do_instr(BR, 32'hFFFF_FFF8, 32'h0, 1'b1);
        chk("br_taken_pc", pc4, 64'h38);

        do_instr(JAL, 32'h8, 32'h0, 1'b0);
        do_instr(BR, 32'hFFFF_FFF8, 32'h0, 1'b0);
        chk("br_not_taken_pc", pc4, 64'h44);

        // update_en is ignored while in REQ
        sel = JAL; imm = 32'h100; update_en = 1'b1;
        step();
        update_en = 1'b0;
        chk("req_ignores_upd_pc", pc4, 64'h44);
        chk("req_ignores_upd_cnt", cnt4, 64'h5);

        // JALR to odd address
        do_instr(JALR, 32'h0, 32'h1003, 1'b0);
        chk("jalr_a2_pc", pc2, 64'h1002);
        chk("jalr_a2_mis", mis2, 64'h0);
        chk("jalr_a4_mis", mis4, 64'h1);
`ifdef PC_TRAP_EN
        chk("jalr_a4_pc", pc4, 64'h100);
        chk("jalr_a4_trap", trap4, 64'h44);
`else
        chk("jalr_a4_pc", pc4, 64'h1000);
        chk("jalr_a4_trap", trap4, 64'h0);
`endif
        chk("jalr_cnt", cnt4, 64'h6);

        do_instr(HOLD, 32'h0, 32'h0, 1'b0);
        chk("hold_pc", pc2, 64'h1002);
        chk("hold_cnt", cnt2, 64'h7);
        chk("mis_pulse_end", mis4, 64'h0);

        // PC wrap
        do_instr(JALR, 32'h0, 32'hFFFF_FFFC, 1'b0);
        chk("jalr_top_pc", pc4, 64'hFFFF_FFFC);
        do_instr(SEQ, 32'h0, 32'h0, 1'b0);
        chk("pc_wrap", pc4, 64'h0);
        chk("pc_wrap_cnt", cnt4, 64'h9);

        // halt wins over update_en
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        halt = 1'b1; update_en = 1'b1; sel = JAL; imm = 32'h40;
        step();
        halt = 1'b0;
        chk("halt_state", hlt4, 64'h1);
        chk("halt_pc", pc4, 64'h0);
        chk("halt_cnt", cnt4, 64'h9);
        chk("halt_req", req4, 64'h0);
        fetch_ack = 1'b1;
        step(); step(); step();
        fetch_ack = 1'b0; update_en = 1'b0;
        chk("halted_sticky_pc", pc4, 64'h0);
        chk("halted_sticky_cnt", cnt4, 64'h9);
        chk("halted_sticky", hlt4, 64'h1);

        // Reset out of HALTED, then reset mid-fetch
        clr = 1'b0;
        step();
        clr = 1'b1;
        chk("rst_from_halt", hlt4, 64'h0);
        step();
        do_instr(SEQ, 32'h0, 32'h0, 1'b0);
        chk("pre_midrst_pc", pc4, 64'h4);
        chk("pre_midrst_req", req4, 64'h1);
        clr = 1'b0;
        step();
        chk("midrst_pc", pc4, 64'h0);
        chk("midrst_req", req4, 64'h0);
        chk("midrst_cnt", cnt4, 64'h0);
        clr = 1'b1; fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("late_ack_req", req4, 64'h1);
        step();
        chk("late_ack_still_req", req4, 64'h1);

        // Counter wrap on the 8-bit instance
        for (int i = 0; i < 255; i++) do_instr(SEQ, 32'h0, 32'h0, 1'b0);
        chk("cnt8_full", cnt8, 64'hFF);
        do_instr(SEQ, 32'h0, 32'h0, 1'b0);
        chk("cnt8_wrap", cnt8, 64'h0);
        chk("cnt32_256", cnt4, 64'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
